// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order requests to instruction memory,
// buffers returned words and presents one {PC+4, instruction} pair per cycle to IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCo,
    output logic [31:0] instructiono,
    output logic        valid_o
);

    localparam int unsigned CntW  = $clog2(FQ_DEPTH + 1);
    localparam int unsigned CntW1 = CntW + 1;
    localparam int unsigned PtrW  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FQ_DEPTH - 1);
    localparam logic [CntW:0]   DepthW  = CntW1'(FQ_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e state_q, state_d;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

    // Tag FIFO: addresses of live outstanding requests; its count is the outstanding count.
    logic [31:0]     tag_mem_q [FQ_DEPTH];
    logic [PtrW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CntW-1:0] tag_cnt_q, tag_cnt_d;

    // Fetch queue entries are {pc_plus4, instruction}.
    logic [63:0]     fq_mem_q [FQ_DEPTH];
    logic [PtrW-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
    logic [CntW-1:0] fq_cnt_q, fq_cnt_d;

    logic [31:0] pco_q, pco_d, instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [CntW:0] in_flight;
    logic [CntW:0] drop_total;
    logic [31:0]   redirect_pc_al;
    logic [31:0]   tag_head;
    logic [63:0]   fq_head;
    logic          issue, resp_drop, resp_keep, fq_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   if (redirect && drop_cnt_d != '0) state_d = StFlush;
            StFlush: if (drop_cnt_d == '0) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_flight = {1'b0, tag_cnt_q} + {1'b0, fq_cnt_q};
        imem_req  = (state_q == StRun) && !redirect && (in_flight < DepthW);
        imem_addr = fetch_pc_q;
    end

    always_comb begin
        redirect_pc_al = redirect_pc & ~32'h3;
        tag_head       = tag_mem_q[tag_rd_q];
        fq_head        = fq_mem_q[fq_rd_q];
        issue          = imem_req && imem_gnt;
        resp_drop      = imem_rvalid && (redirect || drop_cnt_q != '0);
        resp_keep      = imem_rvalid && !resp_drop && (tag_cnt_q != '0);
        fq_pop         = !redirect && !stall && (fq_cnt_q != '0);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        drop_total = '0;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        tag_cnt_d  = tag_cnt_q;
        fq_rd_d    = fq_rd_q;
        fq_wr_d    = fq_wr_q;
        fq_cnt_d   = fq_cnt_q;
        pco_d      = pco_q;
        instr_d    = instr_q;
        valid_d    = valid_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc_al;
            // Every live request becomes stale; a response landing now is one of them.
            drop_total = {1'b0, drop_cnt_q} + {1'b0, tag_cnt_q};
            if (imem_rvalid && drop_total != '0) begin
                drop_total = drop_total - CntW1'(1);
            end
            drop_cnt_d = drop_total[CntW-1:0];
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            tag_cnt_d  = '0;
            fq_rd_d    = '0;
            fq_wr_d    = '0;
            fq_cnt_d   = '0;
            valid_d    = 1'b0;
            instr_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tag_wr_d   = ptr_inc(tag_wr_q);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CntW'(1);
            end
            if (resp_keep) begin
                tag_rd_d = ptr_inc(tag_rd_q);
                fq_wr_d  = ptr_inc(fq_wr_q);
            end
            unique case ({issue, resp_keep})
                2'b10:   tag_cnt_d = tag_cnt_q + CntW'(1);
                2'b01:   tag_cnt_d = tag_cnt_q - CntW'(1);
                default: tag_cnt_d = tag_cnt_q;
            endcase
            unique case ({resp_keep, fq_pop})
                2'b10:   fq_cnt_d = fq_cnt_q + CntW'(1);
                2'b01:   fq_cnt_d = fq_cnt_q - CntW'(1);
                default: fq_cnt_d = fq_cnt_q;
            endcase
            if (!stall) begin
                if (fq_cnt_q != '0) begin
                    fq_rd_d = ptr_inc(fq_rd_q);
                    pco_d   = fq_head[63:32];
                    instr_d = fq_head[31:0];
                    valid_d = 1'b1;
                end else begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            tag_cnt_q  <= '0;
            fq_rd_q    <= '0;
            fq_wr_q    <= '0;
            fq_cnt_q   <= '0;
            pco_q      <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_cnt_q  <= tag_cnt_d;
            fq_rd_q    <= fq_rd_d;
            fq_wr_q    <= fq_wr_d;
            fq_cnt_q   <= fq_cnt_d;
            pco_q      <= pco_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    // Storage needs no reset: the pointers and counts define what is live.
    always_ff @(posedge CLK) begin
        if (issue) begin
            tag_mem_q[tag_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            fq_mem_q[fq_wr_q] <= {tag_head + 32'd4, imem_rdata};
        end
    end

    assign PCo          = pco_q;
    assign instructiono = instr_q;
    assign valid_o      = valid_q;

endmodule
